// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read arbiter and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int          DEFAULT_TIMEOUT_CYC = 1024;
    localparam logic [31:0] TIMEOUT_DATA        = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after ptr_i,
// wrapping modulo N, plus a valid flag. Shared by several arbiters.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int c;

    // NOTE: every output gets a default first, so no path through the block infers a latch.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        // Scan from farthest to nearest so the nearest set request is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr_i) + k) % N;
            if (req_i[c]) begin
                idx_o   = IDX_W'(c);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one word-read memory port between NUM_REQ requesters.
// Define MEM_READ_ARB_TIMEOUT_EN to abort stalled grants after TIMEOUT_CYC cycles.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
`ifdef MEM_READ_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
`endif
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
    output logic [NUM_REQ-1:0]        req_rd_fin,
    output logic [DATA_W-1:0]         req_rd_data,
    output logic                      mem_rd_req,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic                      mem_rd_fin,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      err
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_req_q, mem_req_d;
    logic [NUM_REQ-1:0]  fin_q, fin_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [IDX_W-1:0]    ptr_after_grant;

`ifdef MEM_READ_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req_rd_req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign ptr_after_grant = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        mem_req_d = mem_req_q;
        fin_d     = '0;
        data_d    = data_q;
`ifdef MEM_READ_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick_idx;
                    addr_d    = req_rd_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    mem_req_d = 1'b1;
                    state_d   = ST_BUSY;
`ifdef MEM_READ_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (mem_rd_fin) begin
                    data_d         = mem_rd_data;
                    fin_d[grant_q] = 1'b1;
                    mem_req_d      = 1'b0;
                    ptr_d          = ptr_after_grant;
                    state_d        = ST_RELEASE;
                end
`ifdef MEM_READ_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    data_d         = DATA_W'(TIMEOUT_DATA);
                    fin_d[grant_q] = 1'b1;
                    mem_req_d      = 1'b0;
                    ptr_d          = ptr_after_grant;
                    err_d          = 1'b1;
                    state_d        = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use <= so each one sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            mem_req_q <= 1'b0;
            fin_q     <= '0;
            data_q    <= '0;
`ifdef MEM_READ_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            mem_req_q <= mem_req_d;
            fin_q     <= fin_d;
            data_q    <= data_d;
`ifdef MEM_READ_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign req_rd_fin  = fin_q;
    assign req_rd_data = data_q;
    assign mem_rd_req  = mem_req_q;
    assign mem_rd_addr = addr_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef MEM_READ_ARB_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(N);
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_v = '0;
    logic [N*AW-1:0]   addr_v = '0;
    logic [N-1:0]      req_rd_fin;
    logic [DW-1:0]     req_rd_data;
    logic              mem_rd_req;
    logic [AW-1:0]     mem_rd_addr;
    logic              mem_fin = 1'b0;
    logic [DW-1:0]     mem_data = '0;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
`ifdef MEM_READ_ARB_TIMEOUT_EN
        .TIMEOUT_CYC (TO),
`endif
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_rd_req  (req_v),
        .req_rd_addr (addr_v),
        .req_rd_fin  (req_rd_fin),
        .req_rd_data (req_rd_data),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_fin  (mem_fin),
        .mem_rd_data (mem_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .err         (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding read, a one-cycle pause after each completion,
    // and a rotating priority that starts just past the last winner.
    bit              m_req, m_rel, m_err;
    int              m_grant, m_ptr, m_cnt;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [N-1:0]    m_fin;

    task automatic model_finish(input logic [DW-1:0] d);
        m_data         = d;
        m_fin[m_grant] = 1'b1;
        m_req          = 1'b0;
        m_ptr          = (m_grant + 1) % N;
        m_rel          = 1'b1;
    endtask

    task automatic model_step();
        bit found;
        m_fin = '0;
        if (m_req) begin
            if (mem_fin) begin
                model_finish(mem_data);
            end else begin
`ifdef MEM_READ_ARB_TIMEOUT_EN
                m_cnt++;
                if (m_cnt == TO) begin
                    model_finish(32'hDEAD_BEEF);
                    m_err = 1'b1;
                end
`endif
            end
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else if (req_v != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_v[(m_ptr + k) % N]) begin
                    found   = 1'b1;
                    m_grant = (m_ptr + k) % N;
                end
            end
            m_addr = addr_v[m_grant*AW +: AW];
            m_req  = 1'b1;
            m_cnt  = 0;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            m_req = 0; m_rel = 0; m_err = 0; m_grant = 0; m_ptr = 0; m_cnt = 0;
            m_addr = '0; m_data = '0; m_fin = '0;
        end
        check("model mem_rd_req", mem_rd_req, m_req);
        check("model mem_rd_addr", mem_rd_addr, m_addr);
        check("model req_rd_fin", req_rd_fin, m_fin);
        check("model req_rd_data", req_rd_data, m_data);
        check("model grant_id", grant_id, m_grant);
        check("model busy", busy, m_req || m_rel);
        check("model err", err, m_err);
        if (!reset) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr_v[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req_v   = '0;
        mem_fin = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_mem_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (!ok) begin
                if (mem_rd_req) ok = 1'b1;
                else tick();
            end
        end
    endtask

    int order [6] = '{0, 1, 2, 0, 1, 2};
    int ngr, lat, low_run, hi;
    bit prev_req, ok, mute, prev_m_req;

    initial begin
        // Reset state
        do_reset();
        check("reset mem_rd_req", mem_rd_req, 0);
        check("reset mem_rd_addr", mem_rd_addr, 0);
        check("reset req_rd_fin", req_rd_fin, 0);
        check("reset req_rd_data", req_rd_data, 0);
        check("reset grant_id", grant_id, 0);
        check("reset busy", busy, 0);
        check("reset err", err, 0);

        // Single requester 1 at 0x100, memory answers on the 4th BUSY cycle
        req_v = 3'b010;
        set_addr(1, 32'h100);
        tick();
        check("single mem_rd_req", mem_rd_req, 1);
        check("single mem_rd_addr", mem_rd_addr, 32'h100);
        check("single grant_id", grant_id, 1);
        check("single model addr", m_addr, 32'h100);
        tick(); tick(); tick();
        check("single no early fin", req_rd_fin, 0);
        mem_fin  = 1'b1;
        mem_data = 32'h1234_5678;
        tick();
        mem_fin = 1'b0;
        req_v   = '0;
        check("single fin", req_rd_fin, 3'b010);
        check("single data", req_rd_data, 32'h1234_5678);
        check("single mem_rd_req low", mem_rd_req, 0);
        check("single model fin", m_fin, 3'b010);
        tick();
        check("single fin one cycle", req_rd_fin, 0);
        check("single data held", req_rd_data, 32'h1234_5678);
        check("single back to idle", busy, 0);

        // Spurious memory completion while idle
        mem_fin  = 1'b1;
        mem_data = 32'hAAAA_5555;
        tick();
        mem_fin = 1'b0;
        check("spurious fin", req_rd_fin, 0);
        check("spurious busy", busy, 0);
        check("spurious mem_rd_req", mem_rd_req, 0);
        check("spurious data", req_rd_data, 32'h1234_5678);

        // All three requesting continuously; memory answers on the 2nd BUSY cycle
        do_reset();
        req_v = 3'b111;
        for (int i = 0; i < N; i++) set_addr(i, 32'h1000 + 32'(i));
        ngr = 0; lat = 0; low_run = 0; prev_req = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (ngr < 6) begin
                tick();
                check("rr fin onehot", 64'($countones(req_rd_fin) <= 1), 1);
                if (mem_rd_req && !prev_req) begin
                    check("rr grant order", grant_id, order[ngr]);
                    check("rr addr", mem_rd_addr, 32'h1000 + 32'(order[ngr]));
                    // low during RELEASE and the IDLE arbitration cycle
                    if (ngr > 0) check("rr req low gap", low_run, 2);
                    ngr++;
                    lat = 0;
                end
                if (!mem_rd_req) low_run++;
                else low_run = 0;
                mem_fin = 1'b0;
                if (mem_rd_req) begin
                    lat++;
                    if (lat == 2) begin
                        mem_fin  = 1'b1;
                        mem_data = $urandom;
                    end
                end
                prev_req = mem_rd_req;
            end
        end
        check("rr six grants", ngr, 6);
        mem_fin = 1'b0;

        // Requester 2 drops its request mid-BUSY
        do_reset();
        req_v = 3'b100;
        set_addr(2, 32'h200);
        tick();
        check("drop grant", grant_id, 2);
        req_v = 3'b011;
        tick(); tick();
        mem_fin  = 1'b1;
        mem_data = 32'hCAFE_0002;
        tick();
        mem_fin = 1'b0;
        check("drop fin still pulses", req_rd_fin, 3'b100);
        check("drop data", req_rd_data, 32'hCAFE_0002);
        wait_mem_req(10, ok);
        check("drop next grant seen", ok, 1);
        check("drop next grant wraps", grant_id, 0);

        // Reset two cycles into BUSY with the pointer at 1
        do_reset();
        req_v = 3'b001;
        tick();
        tick();
        mem_fin = 1'b1;
        tick();
        mem_fin = 1'b0;
        req_v   = '0;
        check("rst prior fin", req_rd_fin, 3'b001);
        tick();
        req_v = 3'b100;
        tick();
        check("rst grant before", grant_id, 2);
        tick(); tick();
        reset = 1'b1;
        #1;
        check("rst mem_rd_req drops", mem_rd_req, 0);
        check("rst no fin", req_rd_fin, 0);
        check("rst busy", busy, 0);
        mem_fin = 1'b1;
        tick();
        mem_fin = 1'b0;
        check("rst no fin later", req_rd_fin, 0);
        reset = 1'b0;
        req_v = 3'b101;
        tick();
        check("rst fresh grant from 0", grant_id, 0);
        check("rst fresh mem_rd_req", mem_rd_req, 1);

`ifdef MEM_READ_ARB_TIMEOUT_EN
        // Memory never answers
        do_reset();
        req_v = 3'b010;
        tick();
        req_v = 3'b111;
        hi = 1;
        for (int c = 0; c < 40; c++) begin
            if (req_rd_fin == '0) begin
                tick();
                if (mem_rd_req) hi++;
            end
        end
        check("timeout busy cycles", hi, TO);
        check("timeout fin", req_rd_fin, 3'b010);
        check("timeout data", req_rd_data, 32'hDEAD_BEEF);
        check("timeout err", err, 1);
        req_v = 3'b101;
        wait_mem_req(10, ok);
        check("timeout next grant seen", ok, 1);
        check("timeout next grant", grant_id, 2);
        check("timeout err sticky", err, 1);
`endif

        // Randomized traffic against the model
        do_reset();
        mute = 1'b0;
        prev_m_req = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_v[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_v[i] = 1'b1;
                        set_addr(i, $urandom);
                    end
                end else if (m_fin[i]) begin
                    if ($urandom_range(0, 3) != 0) req_v[i] = 1'b0;
                end else if (m_req && m_grant == i) begin
                    if ($urandom_range(0, 31) == 0) req_v[i] = 1'b0;
                end
                if (!(m_req && m_grant == i) && $urandom_range(0, 1) == 1) set_addr(i, $urandom);
            end
            if (m_req) begin
`ifdef MEM_READ_ARB_TIMEOUT_EN
                if (!prev_m_req) mute = ($urandom_range(0, 7) == 0);
`endif
                mem_fin = !mute && ($urandom_range(0, 3) == 0);
            end else begin
                mem_fin = ($urandom_range(0, 9) == 0);
            end
            mem_data   = $urandom;
            prev_m_req = m_req;
        end
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
